regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (rd/RuWr/RuWrData) between two requesters: the core writeback path and the load-return path.
- Load-return writes come from data memory or MMIO.
- Keeps a pending-load scoreboard so decode can stall on RAW hazards against outstanding loads.
- Sits between the execute/memory stages and the 32x32 register unit.
- Presents a registered write, one cycle after grant.

Parameters:
MAX_WAIT, 4, cycles a valid load return may lose arbitration before it is forced to win (1..15)
MAX_OUTSTANDING, 4, max loads tracked in flight (1..31)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
wb_valid  in  1  core writeback request
wb_rd  in  5  writeback destination
wb_data  in  32  writeback data
wb_ready  out  1  writeback granted this cycle (combinational)
ld_issue  in  1  load issued; marks ld_issue_rd pending
ld_issue_rd  in  5  destination of issued load
ld_issue_ready  out  1  outstanding-load capacity available
ld_valid  in  1  load data return request
ld_rd  in  5  load return destination
ld_data  in  32  load return data
ld_ready  out  1  load return granted this cycle (combinational)
rs1  in  5  decode source 1
rs2  in  5  decode source 2
hazard  out  1  rs1 or rs2 pending (combinational)
rd  out  5  register-unit write select (registered)
RuWr  out  1  register-unit write enable (registered)
RuWrData  out  32  register-unit write data (registered)

Behaviour:
- Reset (sync, rst=1 at posedge):
  - pending[31:0]=0, outstanding=0, starve_cnt=0, state=NORMAL.
  - rd=0, RuWr=0, RuWrData=0.
  - A grant in the reset cycle is discarded.
  - Mid-operation reset drops all pending loads; the first post-reset cycle has RuWr=0.
- Arbitration FSM, states NORMAL and FORCE_LD:
  - NORMAL: wb wins if wb_valid; else ld wins if ld_valid.
  - FORCE_LD: ld wins if ld_valid; wb_ready=0.
- starve_cnt (4 bits) increments each cycle ld_valid && !ld_ready, saturating at MAX_WAIT. It clears on ld grant or when ld_valid=0.
- NORMAL->FORCE_LD on the cycle starve_cnt reaches MAX_WAIT. FORCE_LD->NORMAL on ld grant or when ld_valid=0.
- Handshake: a transfer occurs when valid && ready in the same cycle. Requesters hold rd/data stable while valid && !ready. At most one grant per cycle.
- Write output: a grant at cycle N gives rd/RuWrData = granted rd/data and RuWr=1 at cycle N+1. RuWr=0 when nothing was granted; rd/RuWrData hold their previous values.
- x0: a request with rd=0 is still granted (ready=1) but produces RuWr=0 next cycle.
- Scoreboard:
  - ld_issue && ld_issue_ready && ld_issue_rd!=0 sets pending[ld_issue_rd].
  - ld grant with ld_rd!=0 clears pending[ld_rd].
  - Same register set and cleared in the same cycle: set wins.
  - pending[0] is always 0.
- outstanding (5 bits) counts every accepted ld_issue, including rd=0 issues, and decrements on every ld grant. Simultaneous issue and grant: unchanged.
  - ld_issue_ready = outstanding < MAX_OUTSTANDING.
  - ld_issue while not ready is ignored.
  - ld grant with outstanding=0 is a protocol error: flagged by assertion, counter holds at 0.
- hazard = pending[rs1] | pending[rs2], evaluated on current-cycle state. A load granted this cycle still asserts hazard this cycle and deasserts next cycle. rs1=rs2=0 always gives hazard=0.

Decomposition:
- Package regfile_arb_pkg holds:
  - arb_state_t enum {NORMAL, FORCE_LD}
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32 constants
  - wr_req_t struct {valid, rd, data}
- One sub-module, regfile_scoreboard: the pending bitmap, the outstanding counter, ld_issue_ready and hazard.
- Arbitration FSM and output register stay in the top level.

Test Plan:
- Write and load together: wb_valid=1 (rd=5, 0xDEADBEEF) and ld_valid=1 (rd=6, 0x1234), both held, with MAX_WAIT=4.
  - wb_ready=1 and ld_ready=0 for 4 cycles; ld wins on the 5th cycle.
  - RuWr=1, rd=6, RuWrData=0x1234 one cycle after the ld grant.
- Scoreboard hazard:
  - ld_issue rd=7; next cycle rs1=7 -> hazard=1.
  - ld return rd=7 granted -> hazard still 1 that cycle, 0 the next.
  - RuWr=1, rd=7 at grant+1.
- x0 handling: wb_valid rd=0, data 0xFFFFFFFF -> wb_ready=1, RuWr=0 next cycle. ld_issue rd=0 -> pending stays all-zero, outstanding increments.
- Capacity limit: 4 ld_issues with MAX_OUTSTANDING=4 -> ld_issue_ready=0. A 5th issue is ignored. One ld grant -> ld_issue_ready=1 next cycle.
- Same-cycle set and clear: ld_issue rd=9 in the same cycle as ld grant rd=9 -> pending[9]=1, outstanding unchanged.
- Reset mid-operation: grant wb rd=3 while rst=1 -> RuWr=0 next cycle; pending=0, outstanding=0, hazard=0, state NORMAL.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================
// Package : regfile_arb_pkg  -- shared types for the write arbiter
// Revision: 1.0
// ============================================================
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        FORCE_LD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================
// Module  : regfile_scoreboard  -- pending-load bitmap, in-flight count, RAW hazard
// Revision: 1.0
// ============================================================
module regfile_scoreboard
    import regfile_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic                  ld_grant,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  ld_issue_ready,
    output logic                  hazard
);

    localparam logic [4:0] c_max_out = 5'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_next;
    logic [4:0]          r_outstanding;
    logic [4:0]          w_outstanding_next;
    logic                w_issue_acc;

    assign ld_issue_ready = (r_outstanding < c_max_out);
    assign w_issue_acc    = ld_issue && ld_issue_ready;
    assign hazard         = r_pending[rs1] | r_pending[rs2];

    // Clear before set so a same-cycle issue to the returning register stays pending.
    always_comb begin
        w_pending_next = r_pending;
        if (ld_grant && (ld_rd != '0)) begin
            w_pending_next[ld_rd] = 1'b0;
        end
        if (w_issue_acc && (ld_issue_rd != '0)) begin
            w_pending_next[ld_issue_rd] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_issue_acc && !ld_grant) begin
            w_outstanding_next = r_outstanding + 5'd1;
        end else if (ld_grant && !w_issue_acc && (r_outstanding != '0)) begin
            w_outstanding_next = r_outstanding - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending     <= '0;
            r_outstanding <= '0;
        end else begin
            r_pending     <= w_pending_next;
            r_outstanding <= w_outstanding_next;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(ld_grant && !w_issue_acc && (r_outstanding == '0)));

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================
// Module  : regfile_write_arbiter  -- shares the register-file write port
//           between core writeback and load return, with starvation guard
// Revision: 1.0
// ============================================================
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int MAX_WAIT        = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  wb_ready,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    output logic                  ld_issue_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  RuWr,
    output logic [XLEN-1:0]       RuWrData
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_next;
    logic       w_ld_grant;
    wr_req_t    w_req;

    assign w_ld_grant = ld_valid && ld_ready;

    always_comb begin
        wb_ready      = 1'b0;
        ld_ready      = 1'b0;
        w_state_next  = r_state;
        w_starve_next = '0;

        case (r_state)
            NORMAL: begin
                if (wb_valid) begin
                    wb_ready = 1'b1;
                end else if (ld_valid) begin
                    ld_ready = 1'b1;
                end
            end
            FORCE_LD: begin
                ld_ready = ld_valid;
            end
            default: begin
                ld_ready = 1'b0;
            end
        endcase

        if (ld_valid && !ld_ready) begin
            w_starve_next = (r_starve_cnt == c_max_wait) ? r_starve_cnt : r_starve_cnt + 4'd1;
        end

        // Enter forced mode on the same edge the wait counter hits its limit.
        case (r_state)
            NORMAL:   if (w_starve_next == c_max_wait) w_state_next = FORCE_LD;
            FORCE_LD: if (w_ld_grant || !ld_valid) w_state_next = NORMAL;
            default:  w_state_next = NORMAL;
        endcase
    end

    always_comb begin
        w_req = '0;
        if (wb_valid && wb_ready) begin
            w_req = '{valid: 1'b1, rd: wb_rd, data: wb_data};
        end else if (w_ld_grant) begin
            w_req = '{valid: 1'b1, rd: ld_rd, data: ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= NORMAL;
            r_starve_cnt <= '0;
            rd           <= '0;
            RuWr         <= 1'b0;
            RuWrData     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            RuWr         <= w_req.valid && (w_req.rd != '0);
            if (w_req.valid) begin
                rd       <= w_req.rd;
                RuWrData <= w_req.data;
            end
        end
    end

    regfile_scoreboard #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .ld_issue       (ld_issue),
        .ld_issue_rd    (ld_issue_rd),
        .ld_grant       (w_ld_grant),
        .ld_rd          (ld_rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .ld_issue_ready (ld_issue_ready),
        .hazard         (hazard)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================
// Module  : tb_regfile_write_arbiter  -- directed bench for the write arbiter
// Revision: 1.0
// ============================================================
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, ld_issue, ld_valid;
    logic [4:0]  wb_rd, ld_issue_rd, ld_rd, rs1, rs2;
    logic [31:0] wb_data, ld_data;
    logic        wb_ready, ld_issue_ready, ld_ready, hazard, RuWr;
    logic [4:0]  rd;
    logic [31:0] RuWrData;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .MAX_WAIT        (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_ready       (wb_ready),
        .ld_issue       (ld_issue),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .ld_valid       (ld_valid),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .rs1            (rs1),
        .rs2            (rs2),
        .hazard         (hazard),
        .rd             (rd),
        .RuWr           (RuWr),
        .RuWrData       (RuWrData)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r);
        ld_issue = 1'b1; ld_issue_rd = r;
        step();
        ld_issue = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        rs1 = 0; rs2 = 0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_ruwr", RuWr, 0);
        check("rst_rd", rd, 0);
        check("rst_data", RuWrData, 0);
        check("rst_issue_ready", ld_issue_ready, 1);
        check("rst_hazard", hazard, 0);

        // Contention: wb wins four times, then the starved load is forced through
        issue(5'd6);
        wb_valid = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        ld_valid = 1; ld_rd = 5'd6; ld_data = 32'h0000_1234;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_wb_ready", wb_ready, 1);
            check("cont_ld_ready", ld_ready, 0);
            step();
            check("cont_wb_write", {RuWr, 27'd0, rd}, {1'b1, 27'd0, 5'd5});
            check("cont_wb_data", RuWrData, 32'hDEADBEEF);
        end
        #1;
        check("force_wb_ready", wb_ready, 0);
        check("force_ld_ready", ld_ready, 1);
        step();
        wb_valid = 0; ld_valid = 0;
        check("force_ld_write", {RuWr, 27'd0, rd}, {1'b1, 27'd0, 5'd6});
        check("force_ld_data", RuWrData, 32'h0000_1234);

        // RAW hazard against an outstanding load
        issue(5'd7);
        rs1 = 5'd7;
        #1;
        check("haz_pending", hazard, 1);
        ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h77;
        #1;
        check("haz_ld_ready", ld_ready, 1);
        check("haz_grant_cycle", hazard, 1);
        step();
        ld_valid = 0;
        #1;
        check("haz_cleared", hazard, 0);
        check("haz_write", {RuWr, 27'd0, rd}, {1'b1, 27'd0, 5'd7});
        check("haz_data", RuWrData, 32'h77);

        // x0 writeback and x0 load issue
        rs1 = 0; rs2 = 0;
        wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        #1;
        check("x0_wb_ready", wb_ready, 1);
        step();
        wb_valid = 0;
        check("x0_wb_ruwr", RuWr, 0);
        issue(5'd0);
        #1;
        check("x0_issue_hazard", hazard, 0);
        check("x0_issue_ready", ld_issue_ready, 1);

        // Capacity: outstanding is 1 (x0 load); three more fill it
        issue(5'd10); issue(5'd11);
        #1;
        check("cap_ready_3", ld_issue_ready, 1);
        issue(5'd12);
        #1;
        check("cap_full", ld_issue_ready, 0);
        issue(5'd13);
        rs1 = 5'd13;
        #1;
        check("cap_ignored_hazard", hazard, 0);
        check("cap_still_full", ld_issue_ready, 0);
        rs1 = 0;
        ld_valid = 1; ld_rd = 5'd0; ld_data = 32'hAAAA_5555;
        #1;
        check("cap_x0_ld_ready", ld_ready, 1);
        step();
        ld_valid = 0;
        check("cap_x0_ld_ruwr", RuWr, 0);
        check("cap_ready_again", ld_issue_ready, 1);

        // Same-cycle set and clear of r9 (outstanding 3 -> 2 -> 3 -> 3)
        ld_valid = 1; ld_rd = 5'd10; ld_data = 32'h10;
        step();
        ld_valid = 0;
        issue(5'd9);
        ld_issue = 1; ld_issue_rd = 5'd9;
        ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h99;
        step();
        ld_issue = 0; ld_valid = 0;
        rs1 = 5'd9;
        #1;
        check("sc_pending9", hazard, 1);
        check("sc_write", {RuWr, 27'd0, rd}, {1'b1, 27'd0, 5'd9});
        check("sc_ready_3", ld_issue_ready, 1);
        issue(5'd14);
        #1;
        check("sc_full_4", ld_issue_ready, 0);

        // Mid-operation reset during contention, one cycle before forced mode
        rs1 = 5'd9; rs2 = 5'd14;
        wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h33;
        ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h90;
        for (int i = 0; i < 3; i++) step();
        check("mr_pre_write", {RuWr, 27'd0, rd}, {1'b1, 27'd0, 5'd3});
        rst = 1;
        step();
        rst = 0;
        #1;
        check("mr_ruwr", RuWr, 0);
        check("mr_rd", rd, 0);
        check("mr_hazard", hazard, 0);
        check("mr_issue_ready", ld_issue_ready, 1);
        check("mr_normal_wb", wb_ready, 1);
        check("mr_normal_ld", ld_ready, 0);
        wb_valid = 0; ld_valid = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got %0d expected %0d", 1, 0);
        $fatal(1);
    end

endmodule
`default_nettype wire
